// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default oversampling and parity sense,
// common to the receive frame checker and the transmit parity generator.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } uart_rx_state_e;

   localparam int OVERSAMPLE_DEF = 16;
   localparam bit PAR_EVEN       = 1'b0;
   localparam bit PAR_ODD        = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad line; resets to the idle (high) level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_in,
   output logic rxs
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b1;
         rxs  <= 1'b1;
      end else begin
         meta <= rx_in;
         rxs  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive deserializer with parity and stop-bit checking, paced by the shared baud tick.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level to begin a start bit
// START     | timing to mid start bit; high there means a glitch, not a frame
// DATA      | sampling WIDTH data bits LSB first, one per bit period
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, then publishing the frame result
// WAIT_HIGH | stop bit was low (break); hold off until the line returns high
module uart_rx_frame_check
   import uart_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter bit PARITY_ODD = PAR_EVEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             baud_tick,
   input  logic             rx_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             parity_err,
   output logic             frame_err,
   output logic             busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

   uart_rx_state_e   state, state_nxt;
   logic             rxs;
   logic [TW-1:0]    tick_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_reg;
   logic             p_rx;
   logic             tick_mid, tick_last;
   logic             tick_clr, tick_inc, bit_clr, bit_inc, shift_en, p_en, done;

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .rx_in (rx_in),
      .rxs   (rxs)
   );

   assign tick_mid  = (tick_cnt == TICK_MID);
   assign tick_last = (tick_cnt == TICK_LAST);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Everything, including start detection, is gated by baud_tick so a stalled tick freezes the FSM.
   always_comb begin
      state_nxt = state;
      tick_clr  = 1'b0;
      tick_inc  = 1'b0;
      bit_clr   = 1'b0;
      bit_inc   = 1'b0;
      shift_en  = 1'b0;
      p_en      = 1'b0;
      done      = 1'b0;
      if (baud_tick) begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state_nxt = START;
                  tick_clr  = 1'b1;
               end
            end
            START: begin
               if (tick_mid) begin
                  tick_clr = 1'b1;
                  if (rxs) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = DATA;
                     bit_clr   = 1'b1;
                  end
               end else begin
                  tick_inc = 1'b1;
               end
            end
            DATA: begin
               if (tick_last) begin
                  tick_clr = 1'b1;
                  shift_en = 1'b1;
                  if (bit_cnt == BIT_LAST) state_nxt = PARITY;
                  else                     bit_inc   = 1'b1;
               end else begin
                  tick_inc = 1'b1;
               end
            end
            PARITY: begin
               if (tick_last) begin
                  tick_clr  = 1'b1;
                  p_en      = 1'b1;
                  state_nxt = STOP;
               end else begin
                  tick_inc = 1'b1;
               end
            end
            STOP: begin
               if (tick_last) begin
                  tick_clr  = 1'b1;
                  done      = 1'b1;
                  state_nxt = rxs ? IDLE : WAIT_HIGH;
               end else begin
                  tick_inc = 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         p_rx       <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= done;
         if (tick_clr)      tick_cnt <= '0;
         else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;
         if (bit_clr)       bit_cnt  <= '0;
         else if (bit_inc)  bit_cnt  <= bit_cnt + 1'b1;
         if (shift_en)      shift_reg[bit_cnt] <= rxs;
         if (p_en)          p_rx <= rxs;
         // Stop-bit sample and frame result land together; flags hold until the next frame.
         if (done) begin
            data_out   <= shift_reg;
            parity_err <= ((^shift_reg) ^ p_rx) != PARITY_ODD;
            frame_err  <= ~rxs;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench: an even-parity and an odd-parity receiver, each on its own serial line.
module tb_uart_rx_frame_check;

   localparam int OS = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_tick = 1'b0;
   logic       rx_e = 1'b1;
   logic       rx_o = 1'b1;
   logic [7:0] dout_e, dout_o;
   logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

   rec_t exp_e[$], exp_o[$], obs_e[$], obs_o[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   div      = 0;

   uart_rx_frame_check #(.WIDTH(8), .OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut_e (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_e),
      .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e), .busy(busy_e));

   uart_rx_frame_check #(.WIDTH(8), .OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut_o (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_o),
      .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o), .busy(busy_o));

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      baud_tick = (div == 3);
      div = (div + 1) % 4;
   end

   initial forever begin
      @(negedge clk);
      if (dv_e === 1'b1) obs_e.push_back({dout_e, pe_e, fe_e});
      if (dv_o === 1'b1) obs_o.push_back({dout_o, pe_o, fe_o});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no completion, expected completion");
      $fatal(1);
   end

   function automatic logic par_bit(input logic [7:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge clk); while (baud_tick !== 1'b1);
         #2;
      end
   endtask

   task automatic set_rx(input logic sel, input logic v);
      if (sel) rx_o = v;
      else     rx_e = v;
   endtask

   task automatic send_bit(input logic sel, input logic v);
      set_rx(sel, v);
      wait_ticks(OS);
   endtask

   // Leaves the line low after a low stop bit so the caller decides when it recovers.
   task automatic send_frame(input logic sel, input logic [7:0] d, input logic par,
                             input logic stop, input int extra_low);
      send_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
      send_bit(sel, par);
      send_bit(sel, stop);
      if (!stop) repeat (extra_low) send_bit(sel, 1'b0);
   endtask

   task automatic test_reset();
      #3 rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (dout_e !== 8'h00) $display("FAIL reset_data_out: got %h expected 00", dout_e); else n_pass++;
      n_checks++; if (dv_e !== 1'b0) $display("FAIL reset_data_valid: got %b expected 0", dv_e); else n_pass++;
      n_checks++; if (pe_e !== 1'b0) $display("FAIL reset_parity_err: got %b expected 0", pe_e); else n_pass++;
      n_checks++; if (fe_e !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", fe_e); else n_pass++;
      n_checks++; if (busy_e !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_e); else n_pass++;
      #2 rst = 1'b1;
      wait_ticks(4);
      n_checks++; if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy_o); else n_pass++;
   endtask

   task automatic test_good_frame();
      rec_t ob, ex;
      exp_e.push_back({8'hA5, 1'b0, 1'b0});
      send_frame(1'b0, 8'hA5, par_bit(8'hA5, 1'b0), 1'b1, 0);
      for (int i = 0; i < 400 && obs_e.size() < 1; i++) @(negedge clk);
      n_checks++; if (obs_e.size() !== 1) $display("FAIL good_count: got %0d frames expected 1", obs_e.size()); else n_pass++;
      if (obs_e.size() > 0) begin
         ob = obs_e.pop_front(); ex = exp_e.pop_front();
         n_checks++;
         if (ob !== ex) $display("FAIL good_frame: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b", ob.d, ob.pe, ob.fe, ex.d, ex.pe, ex.fe);
         else n_pass++;
      end
      obs_e.delete(); exp_e.delete();
   endtask

   task automatic test_parity_err();
      rec_t ob, ex;
      exp_e.push_back({8'hA5, 1'b1, 1'b0});
      send_frame(1'b0, 8'hA5, ~par_bit(8'hA5, 1'b0), 1'b1, 0);
      for (int i = 0; i < 400 && obs_e.size() < 1; i++) @(negedge clk);
      n_checks++; if (obs_e.size() !== 1) $display("FAIL parity_count: got %0d frames expected 1", obs_e.size()); else n_pass++;
      if (obs_e.size() > 0) begin
         ob = obs_e.pop_front(); ex = exp_e.pop_front();
         n_checks++;
         if (ob !== ex) $display("FAIL parity_frame: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b", ob.d, ob.pe, ob.fe, ex.d, ex.pe, ex.fe);
         else n_pass++;
      end
      obs_e.delete(); exp_e.delete();
   endtask

   task automatic test_frame_err();
      rec_t ob, ex;
      exp_e.push_back({8'h3C, 1'b0, 1'b1});
      send_frame(1'b0, 8'h3C, par_bit(8'h3C, 1'b0), 1'b0, 2);
      n_checks++; if (busy_e !== 1'b1) $display("FAIL break_busy: got %b expected 1", busy_e); else n_pass++;
      set_rx(1'b0, 1'b1);
      wait_ticks(4);
      n_checks++; if (busy_e !== 1'b0) $display("FAIL break_release_busy: got %b expected 0", busy_e); else n_pass++;
      n_checks++; if (obs_e.size() !== 1) $display("FAIL break_count: got %0d frames expected 1", obs_e.size()); else n_pass++;
      if (obs_e.size() > 0) begin
         ob = obs_e.pop_front(); ex = exp_e.pop_front();
         n_checks++;
         if (ob !== ex) $display("FAIL break_frame: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b", ob.d, ob.pe, ob.fe, ex.d, ex.pe, ex.fe);
         else n_pass++;
      end
      obs_e.delete(); exp_e.delete();
   endtask

   task automatic test_glitch();
      set_rx(1'b0, 1'b0);
      wait_ticks(4);
      n_checks++; if (busy_e !== 1'b1) $display("FAIL glitch_busy: got %b expected 1", busy_e); else n_pass++;
      set_rx(1'b0, 1'b1);
      wait_ticks(OS);
      n_checks++; if (busy_e !== 1'b0) $display("FAIL glitch_reject_busy: got %b expected 0", busy_e); else n_pass++;
      n_checks++; if (obs_e.size() !== 0) $display("FAIL glitch_count: got %0d frames expected 0", obs_e.size()); else n_pass++;
      obs_e.delete();
   endtask

   task automatic test_reset_mid();
      rec_t ob, ex;
      logic [7:0] d;
      d = 8'h81;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, d[i]);
      set_rx(1'b0, d[4]);
      wait_ticks(OS/2);
      rst = 1'b0;
      #1;
      n_checks++; if (dout_e !== 8'h00) $display("FAIL midrst_data_out: got %h expected 00", dout_e); else n_pass++;
      n_checks++; if (fe_e !== 1'b0) $display("FAIL midrst_frame_err: got %b expected 0", fe_e); else n_pass++;
      n_checks++; if (busy_e !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_e); else n_pass++;
      n_checks++; if (dv_e !== 1'b0) $display("FAIL midrst_data_valid: got %b expected 0", dv_e); else n_pass++;
      set_rx(1'b0, 1'b1);
      wait_ticks(4);
      rst = 1'b1;
      wait_ticks(2*OS);
      n_checks++; if (obs_e.size() !== 0) $display("FAIL midrst_count: got %0d frames expected 0", obs_e.size()); else n_pass++;
      obs_e.delete();
      exp_e.push_back({8'h81, 1'b0, 1'b0});
      send_frame(1'b0, 8'h81, par_bit(8'h81, 1'b0), 1'b1, 0);
      for (int i = 0; i < 400 && obs_e.size() < 1; i++) @(negedge clk);
      n_checks++; if (obs_e.size() !== 1) $display("FAIL after_rst_count: got %0d frames expected 1", obs_e.size()); else n_pass++;
      if (obs_e.size() > 0) begin
         ob = obs_e.pop_front(); ex = exp_e.pop_front();
         n_checks++;
         if (ob !== ex) $display("FAIL after_rst_frame: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b", ob.d, ob.pe, ob.fe, ex.d, ex.pe, ex.fe);
         else n_pass++;
      end
      obs_e.delete(); exp_e.delete();
   endtask

   task automatic test_back_to_back();
      rec_t ob, ex;
      logic [7:0] vals [2];
      vals[0] = 8'h00;
      vals[1] = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         exp_o.push_back({vals[k], 1'b0, 1'b0});
         send_frame(1'b1, vals[k], par_bit(vals[k], 1'b1), 1'b1, 0);
      end
      for (int i = 0; i < 400 && obs_o.size() < 2; i++) @(negedge clk);
      n_checks++; if (obs_o.size() !== 2) $display("FAIL b2b_count: got %0d frames expected 2", obs_o.size()); else n_pass++;
      while (obs_o.size() > 0 && exp_o.size() > 0) begin
         ob = obs_o.pop_front(); ex = exp_o.pop_front();
         n_checks++;
         if (ob !== ex) $display("FAIL b2b_frame: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b", ob.d, ob.pe, ob.fe, ex.d, ex.pe, ex.fe);
         else n_pass++;
      end
      n_checks++; if (busy_o !== 1'b0) $display("FAIL b2b_busy: got %b expected 0", busy_o); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_err();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
